coffee_sequencer: RTL and testbench
===================================

COFFEE_SEQUENCER -- requirements
Module: coffee_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 50_000_000, cycles per brewing phase (AGUA, CAFE, LECHE, AZUCAR, CREMA).
REQ-002 SHALL have parameter FIN_CYCLES, default 100_000_000, cycles the FIN phase is held.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a drink; level sampled each cycle.
REQ-006 SHALL have port coffee_sel  input  2  0 espresso, 1 leche, 2 capuchino, 3 invalid.
REQ-007 SHALL have port sugar_en  input  1  add AZUCAR phase.
REQ-008 SHALL have port cancel  input  1  abort current drink.
REQ-009 SHALL have port type_char  output  4  display code for drink type: 0 E, 1 L, 2 C, 15 blank.
REQ-010 SHALL have port state_char  output  4  display code for phase: 3 AGUA, 4 CAFE, 5 LECHE, 6 AZUCAR, 7 CREMA, 8 FIN, 15 blank.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, AGUA, CAFE, LECHE, AZUCAR, CREMA, FIN; all outputs registered.
REQ-014 In IDLE: type_char=15, state_char=15, busy=0.
REQ-015 Start accepted only in IDLE with start=1 and coffee_sel!=3; coffee_sel and sugar_en latched in that cycle; next cycle state=AGUA, type_char=coffee_sel, busy=1.
REQ-016 start with coffee_sel=3 SHALL be ignored (stay IDLE, no output change).
REQ-017 start while busy SHALL be ignored; latched recipe unchanged.
REQ-018 Recipes: espresso AGUA,CAFE,[AZUCAR],FIN; leche AGUA,CAFE,LECHE,[AZUCAR],FIN; capuchino AGUA,CAFE,LECHE,[AZUCAR],CREMA,FIN; [AZUCAR] only if latched sugar_en=1.
REQ-019 Each brewing phase SHALL last exactly STEP_CYCLES cycles; FIN SHALL last exactly FIN_CYCLES cycles, then IDLE.
REQ-020 Phase counter width SHALL be $clog2(max(STEP_CYCLES,FIN_CYCLES)+1); cleared on every state change; no wrap inside a phase.
REQ-021 state_char SHALL equal the code of the current state in the same cycle the state register holds it.
REQ-022 done SHALL be 1 for exactly the first cycle in IDLE following FIN, else 0; also asserted after a cancelled drink.
REQ-023 cancel=1 in AGUA..CREMA SHALL move to FIN next cycle with counter cleared; FIN then runs full FIN_CYCLES.
REQ-024 cancel in IDLE or FIN SHALL be ignored; start and cancel together in IDLE: start wins.
REQ-025 Inputs change of coffee_sel/sugar_en during a drink SHALL have no effect.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, counter 0, type_char=15, state_char=15, busy=0, done=0, latched recipe cleared.
REQ-027 rst SHALL take priority over start and cancel in the same cycle.
REQ-028 Reset mid-drink SHALL abort without a done pulse.

Verification (STEP_CYCLES=4, FIN_CYCLES=6; start pulsed at cycle 0)
REQ-029 Espresso, sugar_en=0 -> state_char 3 cycles 1-4, 4 cycles 5-8, 8 cycles 9-14, 15 at 15; type_char=0 cycles 1-14; done=1 only cycle 15.
REQ-030 Capuchino, sugar_en=1 -> state_char 3,4,5,6,7 each 4 cycles (1-20), 8 cycles 21-26; done at 27; type_char=2.
REQ-031 Leche, cancel=1 at cycle 6 (in CAFE) -> state_char=8 cycles 7-12, done at 13, LECHE never shown.
REQ-032 start with coffee_sel=3 -> outputs stay 15/15, busy=0; start (coffee_sel=1) at cycle 2 of an espresso -> type_char stays 0, sequence unchanged.
REQ-033 rst at cycle 10 during leche (LECHE) -> cycle 11 type_char=15, state_char=15, busy=0, done never asserted; new start then behaves per REQ-029.

Source files
------------

// File: rtl/coffee_sequencer.sv
// rtl/coffee_sequencer.sv - drink brewing phase sequencer with display codes
module coffee_sequencer #(
  parameter int STEP_CYCLES = 50_000_000,
  parameter int FIN_CYCLES  = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] coffee_sel,
  input  logic       sugar_en,
  input  logic       cancel,
  output logic [3:0] type_char,
  output logic [3:0] state_char,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_AGUA, S_CAFE, S_LECHE, S_AZUCAR, S_CREMA, S_FIN
  } state_t;

  localparam int MAX_CYCLES = (STEP_CYCLES > FIN_CYCLES) ? STEP_CYCLES : FIN_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] FIN_LAST  = CW'(FIN_CYCLES - 1);
  localparam logic [1:0] SEL_ESPRESSO  = 2'd0;
  localparam logic [1:0] SEL_CAPUCHINO = 2'd2;
  localparam logic [1:0] SEL_INVALID   = 2'd3;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          sugar_q, sugar_d;
  logic [3:0]    type_char_q, type_char_d;
  logic [3:0]    state_char_q, state_char_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [3:0] char_of(input state_t s);
    case (s)
      S_AGUA:   char_of = 4'd3;
      S_CAFE:   char_of = 4'd4;
      S_LECHE:  char_of = 4'd5;
      S_AZUCAR: char_of = 4'd6;
      S_CREMA:  char_of = 4'd7;
      S_FIN:    char_of = 4'd8;
      default:  char_of = 4'd15;
    endcase
  endfunction

  // Recipe walk: the optional AZUCAR always sits just before CREMA/FIN.
  function automatic state_t next_phase(input state_t s, input logic [1:0] sel, input logic sug);
    case (s)
      S_AGUA:   next_phase = S_CAFE;
      S_CAFE:   next_phase = (sel != SEL_ESPRESSO) ? S_LECHE : (sug ? S_AZUCAR : S_FIN);
      S_LECHE:  next_phase = sug ? S_AZUCAR : ((sel == SEL_CAPUCHINO) ? S_CREMA : S_FIN);
      S_AZUCAR: next_phase = (sel == SEL_CAPUCHINO) ? S_CREMA : S_FIN;
      default:  next_phase = S_FIN;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sel_d   = sel_q;
    sugar_d = sugar_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && coffee_sel != SEL_INVALID) begin
          state_d = S_AGUA;
          sel_d   = coffee_sel;
          sugar_d = sugar_en;
        end
      end
      S_FIN: begin
        if (cnt_q == FIN_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (cancel) begin
          state_d = S_FIN;
        end else if (cnt_q == STEP_LAST) begin
          state_d = next_phase(state_q, sel_q, sugar_q);
        end
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
    type_char_d  = (state_d == S_IDLE) ? 4'd15 : {2'b00, sel_d};
    state_char_d = char_of(state_d);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      sugar_q      <= 1'b0;
      type_char_q  <= 4'd15;
      state_char_q <= 4'd15;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      sugar_q      <= sugar_d;
      type_char_q  <= type_char_d;
      state_char_q <= state_char_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign type_char  = type_char_q;
  assign state_char = state_char_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_coffee_sequencer.sv
// tb/tb_coffee_sequencer.sv - cycle-table bench for coffee_sequencer
module tb_coffee_sequencer;

  localparam int STEP = 4;
  localparam int FIN  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] coffee_sel = 2'd0;
  logic       sugar_en = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] type_char;
  logic [3:0] state_char;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  coffee_sequencer #(.STEP_CYCLES(STEP), .FIN_CYCLES(FIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .coffee_sel (coffee_sel),
    .sugar_en   (sugar_en),
    .cancel     (cancel),
    .type_char  (type_char),
    .state_char (state_char),
    .busy       (busy),
    .done       (done)
  );

  // One record per cycle: inputs driven in cycle k, outputs expected in cycle k+1.
  typedef struct {
    logic       st;
    logic [1:0] sel;
    logic       sug;
    logic       can;
    logic       rs;
    logic [3:0] et;
    logic [3:0] es;
    logic       eb;
    logic       ed;
    int         tag;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add_vec(input logic st, input logic [1:0] sel, input logic sug,
                         input logic can, input logic rs, input logic [3:0] et,
                         input logic [3:0] es, input logic eb, input logic ed, input int tag);
    vec_t v;
    v.st = st; v.sel = sel; v.sug = sug; v.can = can; v.rs = rs;
    v.et = et; v.es = es; v.eb = eb; v.ed = ed; v.tag = tag;
    vecs.push_back(v);
  endtask

  // Idle-input cycles; selector and sugar wander to show they are ignored mid-drink.
  task automatic hold(input int n, input logic [3:0] et, input logic [3:0] es, input int tag);
    for (int i = 0; i < n; i++)
      add_vec(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
              et, es, (es != 4'd15), 1'b0, tag);
  endtask

  task automatic idle_done(input int tag);
    add_vec(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b1, tag);
  endtask

  task automatic add_drink(input logic [1:0] sel, input logic sug, input int tag);
    logic [3:0] t;
    t = {2'b00, sel};
    add_vec(1'b1, sel, sug, 1'b0, 1'b0, t, 4'd3, 1'b1, 1'b0, tag);
    hold(STEP - 1, t, 4'd3, tag);
    hold(STEP, t, 4'd4, tag);
    if (sel != 2'd0) hold(STEP, t, 4'd5, tag);
    if (sug) hold(STEP, t, 4'd6, tag);
    if (sel == 2'd2) hold(STEP, t, 4'd7, tag);
    hold(FIN, t, 4'd8, tag);
    idle_done(tag);
    hold(1, 4'd15, 4'd15, tag);
  endtask

  task automatic chk(input string nm, input int idx, input int tag,
                     input logic [3:0] got, input logic [3:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s vec %0d tag %0d: got %0d expected %0d", nm, idx, tag, got, want);
    end
  endtask

  initial begin
    vec_t e;

    add_vec(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0, 1);
    add_vec(1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 1);

    add_drink(2'd0, 1'b0, 2);
    add_drink(2'd2, 1'b1, 3);
    add_drink(2'd1, 1'b0, 4);
    add_drink(2'd0, 1'b1, 5);
    add_drink(2'd1, 1'b1, 6);

    add_vec(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 7);
    add_vec(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 7);

    // Second start (leche + sugar) during an espresso must not alter the recipe.
    add_vec(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 8);
    add_vec(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 8);
    add_vec(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 8);
    hold(1, 4'd0, 4'd3, 8);
    hold(STEP, 4'd0, 4'd4, 8);
    hold(FIN, 4'd0, 4'd8, 8);
    idle_done(8);

    // Leche cancelled in CAFE at cycle 6: FIN 7-12, done 13.
    add_vec(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b0, 9);
    hold(3, 4'd1, 4'd3, 9);
    hold(2, 4'd1, 4'd4, 9);
    add_vec(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd8, 1'b1, 1'b0, 9);
    hold(FIN - 1, 4'd1, 4'd8, 9);
    idle_done(9);
    hold(1, 4'd15, 4'd15, 9);

    // Reset at cycle 10 (in LECHE) together with start and cancel: no done pulse.
    add_vec(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b0, 10);
    hold(3, 4'd1, 4'd3, 10);
    hold(4, 4'd1, 4'd4, 10);
    hold(2, 4'd1, 4'd5, 10);
    add_vec(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0, 10);
    hold(3, 4'd15, 4'd15, 10);
    add_drink(2'd0, 1'b0, 11);

    // start+cancel in IDLE: start wins; cancel in CREMA; cancel in FIN ignored.
    add_vec(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 4'd2, 4'd3, 1'b1, 1'b0, 12);
    hold(3, 4'd2, 4'd3, 12);
    hold(4, 4'd2, 4'd4, 12);
    hold(4, 4'd2, 4'd5, 12);
    hold(2, 4'd2, 4'd7, 12);
    add_vec(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd8, 1'b1, 1'b0, 12);
    hold(2, 4'd2, 4'd8, 12);
    add_vec(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd8, 1'b1, 1'b0, 12);
    hold(2, 4'd2, 4'd8, 12);
    idle_done(12);
    hold(1, 4'd15, 4'd15, 12);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start      = vecs[i].st;
      coffee_sel = vecs[i].sel;
      sugar_en   = vecs[i].sug;
      cancel     = vecs[i].can;
      rst        = vecs[i].rs;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("type_char", i, e.tag, type_char, e.et);
      chk("state_char", i, e.tag, state_char, e.es);
      chk("busy", i, e.tag, {3'b000, busy}, {3'b000, e.eb});
      chk("done", i, e.tag, {3'b000, done}, {3'b000, e.ed});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
